// File: rtl/lsu_apb_master.sv
// Load/store unit front end: turns one core load/store request into one APB transfer to an SRAM slave.
// Optional feature: define LSU_TIMEOUT_EN to abort ACCESS after 16 cycles without pready.
module lsu_apb_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  pclk,
    input  logic                  prst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pdata,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [3:0]            pstb,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  perr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                  state_q;
    logic [1:0]              size_q;
    logic                    unsigned_q;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic [DATA_WIDTH-1:0]   pdata_q;
    logic                    psel_q;
    logic                    penable_q;
    logic                    pwrite_q;
    logic [3:0]              pstb_q;
    logic                    resp_valid_q;
    logic                    resp_err_q;
    logic [DATA_WIDTH-1:0]   resp_rdata_q;
`ifdef LSU_TIMEOUT_EN
    logic [3:0]              tmo_q;
`endif

    function automatic logic [3:0] size_to_stb(input logic [1:0] sz);
        case (sz)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Slave has already steered the addressed bytes down to the low lanes.
    function automatic logic [DATA_WIDTH-1:0] extend_load(input logic [DATA_WIDTH-1:0] d,
                                                          input logic [1:0] sz,
                                                          input logic uns);
        case (sz)
            2'b00: return uns ? {{(DATA_WIDTH-8){1'b0}}, d[7:0]}
                              : {{(DATA_WIDTH-8){d[7]}}, d[7:0]};
            2'b01: return uns ? {{(DATA_WIDTH-16){1'b0}}, d[15:0]}
                              : {{(DATA_WIDTH-16){d[15]}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    assign req_ready  = (state_q == IDLE) && !prst;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign paddr      = paddr_q;
    assign pdata      = pdata_q;
    assign psel       = psel_q;
    assign penable    = penable_q;
    assign pwrite     = pwrite_q;
    assign pstb       = pstb_q;

    always_ff @(posedge pclk) begin
        if (prst) begin
            state_q      <= IDLE;
            size_q       <= 2'b00;
            unsigned_q   <= 1'b0;
            paddr_q      <= '0;
            pdata_q      <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            pstb_q       <= 4'b0000;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
`ifdef LSU_TIMEOUT_EN
            tmo_q        <= 4'd0;
`endif
        end else begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        if (req_size == 2'b11) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else begin
                            state_q    <= SETUP;
                            size_q     <= req_size;
                            unsigned_q <= req_unsigned;
                            paddr_q    <= req_addr;
                            pdata_q    <= req_wdata;
                            pwrite_q   <= req_write;
                            pstb_q     <= size_to_stb(req_size);
                            psel_q     <= 1'b1;
                            penable_q  <= 1'b0;
                        end
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
`ifdef LSU_TIMEOUT_EN
                    tmo_q     <= 4'd0;
`endif
                end
                ACCESS: begin
                    if (pready) begin
                        state_q      <= RESP;
                        psel_q       <= 1'b0;
                        penable_q    <= 1'b0;
                        pwrite_q     <= 1'b0;
                        pstb_q       <= 4'b0000;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= perr;
                        resp_rdata_q <= (perr || pwrite_q) ? '0
                                        : extend_load(prdata, size_q, unsigned_q);
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (tmo_q == 4'd15) begin
                        // 16th ACCESS cycle without pready: give up on the slave.
                        state_q      <= RESP;
                        psel_q       <= 1'b0;
                        penable_q    <= 1'b0;
                        pwrite_q     <= 1'b0;
                        pstb_q       <= 4'b0000;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 4'd1;
                    end
`endif
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_apb_master.sv
// Directed self-checking bench for lsu_apb_master with a small APB slave model of programmable wait states.
// Define LSU_TIMEOUT_EN for both bench and RTL to exercise the ACCESS timeout.
module tb_lsu_apb_master;

    logic        pclk = 1'b0;
    logic        prst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] paddr;
    logic [31:0] pdata;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [3:0]  pstb;
    logic [31:0] prdata;
    logic        pready;
    logic        perr;

    // Slave model: pready after wait_cfg stalled ACCESS cycles
    int          wait_cfg;
    int          acc_cnt;
    logic [31:0] rdata_cfg;
    logic        perr_cfg;

    int n_checks = 0;
    int n_pass   = 0;

    // Per-transaction observations
    int          lat;
    logic        got_resp;
    logic [31:0] got_rdata;
    logic        got_err;
    logic        saw_psel;
    logic        unstable;
    logic [31:0] s_paddr;
    logic [31:0] s_pdata;
    logic [3:0]  s_pstb;
    logic        s_pwrite;

    always #5 pclk = ~pclk;

    assign pready = psel && penable && (acc_cnt == wait_cfg);
    assign prdata = rdata_cfg;
    assign perr   = perr_cfg;

    always @(posedge pclk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
    end

    lsu_apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .pclk        (pclk),
        .prst        (prst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .paddr       (paddr),
        .pdata       (pdata),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .pstb        (pstb),
        .prdata      (prdata),
        .pready      (pready),
        .perr        (perr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Issue one request and follow it until resp_valid or the cycle budget runs out.
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [1:0] sz, input logic uns, input int budget);
        req_valid    = 1'b1;
        req_write    = wr;
        req_addr     = addr;
        req_wdata    = wd;
        req_size     = sz;
        req_unsigned = uns;
        tick();
        req_valid = 1'b0;
        lat = 1; got_resp = 1'b0; saw_psel = 1'b0; unstable = 1'b0;
        got_rdata = '0; got_err = 1'b0;
        while (lat <= budget && !got_resp) begin
            if (psel && !penable) begin
                saw_psel = 1'b1;
                s_paddr = paddr; s_pdata = pdata; s_pstb = pstb; s_pwrite = pwrite;
            end else if (psel && penable) begin
                if (paddr !== s_paddr || pdata !== s_pdata || pstb !== s_pstb || pwrite !== s_pwrite)
                    unstable = 1'b1;
            end
            if (resp_valid) begin
                got_resp = 1'b1; got_rdata = resp_rdata; got_err = resp_err;
            end else begin
                tick();
                lat++;
            end
        end
        $display("txn wr=%0b addr=%08h size=%0d uns=%0b -> resp=%0b lat=%0d err=%0b rdata=%08h",
                 wr, addr, sz, uns, got_resp, lat, got_err, got_rdata);
    endtask

    // Directed load vectors: size, unsigned, prdata, expected resp_rdata
    typedef struct {
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] rd;
        logic [31:0] exp;
    } ld_vec_t;

    ld_vec_t ld_vecs[5];

    initial begin
        ld_vecs[0] = '{2'b01, 1'b0, 32'h1234_8001, 32'hFFFF_8001};
        ld_vecs[1] = '{2'b01, 1'b1, 32'h1234_F00D, 32'h0000_F00D};
        ld_vecs[2] = '{2'b00, 1'b0, 32'hAB12_347F, 32'h0000_007F};
        ld_vecs[3] = '{2'b10, 1'b0, 32'h8000_0001, 32'h8000_0001};
        ld_vecs[4] = '{2'b01, 1'b0, 32'h0000_7FFF, 32'h0000_7FFF};

        prst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = 2'b00; req_unsigned = 1'b0;
        wait_cfg = 0; rdata_cfg = '0; perr_cfg = 1'b0;
        tick();
        tick();
        check("rst_psel",       {31'd0, psel},       32'd0);
        check("rst_penable",    {31'd0, penable},    32'd0);
        check("rst_pstb",       {28'd0, pstb},       32'd0);
        check("rst_paddr",      paddr,               32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_ready_low",  {31'd0, req_ready},  32'd0);
        prst = 1'b0;
        #1;
        check("rst_ready_high", {31'd0, req_ready},  32'd1);

        // Word store, zero-wait slave
        do_req(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 2'b10, 1'b0, 20);
        check("st_resp",    {31'd0, got_resp}, 32'd1);
        check("st_lat",     lat,               32'd3);
        check("st_setup",   {31'd0, saw_psel}, 32'd1);
        check("st_paddr",   s_paddr,           32'h0000_0100);
        check("st_pdata",   s_pdata,           32'hDEAD_BEEF);
        check("st_pstb",    {28'd0, s_pstb},   32'hF);
        check("st_pwrite",  {31'd0, s_pwrite}, 32'd1);
        check("st_err",     {31'd0, got_err},  32'd0);
        check("st_rdata",   got_rdata,         32'd0);
        check("st_apb_idle", {29'd0, psel, penable, pwrite}, 32'd0);
        tick();
        check("st_pulse",   {31'd0, resp_valid}, 32'd0);
        check("st_ready",   {31'd0, req_ready},  32'd1);

        // Signed then unsigned byte load from an odd address, back to back
        rdata_cfg = 32'h0000_00F0;
        do_req(1'b0, 32'h0000_0101, 32'h0, 2'b00, 1'b0, 20);
        check("lbs_lat",    lat,               32'd3);
        check("lbs_paddr",  s_paddr,           32'h0000_0101);
        check("lbs_pstb",   {28'd0, s_pstb},   32'h1);
        check("lbs_pwrite", {31'd0, s_pwrite}, 32'd0);
        check("lbs_rdata",  got_rdata,         32'hFFFF_FFF0);
        tick();
        do_req(1'b0, 32'h0000_0101, 32'h0, 2'b00, 1'b1, 20);
        check("lbu_rdata",  got_rdata,         32'h0000_00F0);
        tick();

        // Half load with 4 wait states and slave error
        wait_cfg = 4; perr_cfg = 1'b1; rdata_cfg = 32'h0000_8001;
        do_req(1'b0, 32'h0000_0202, 32'h5555_AAAA, 2'b01, 1'b0, 30);
        check("lhw_lat",    lat,               32'd7);
        check("lhw_stable", {31'd0, unstable}, 32'd0);
        check("lhw_pstb",   {28'd0, s_pstb},   32'h3);
        check("lhw_err",    {31'd0, got_err},  32'd1);
        check("lhw_rdata",  got_rdata,         32'd0);
        tick();
        wait_cfg = 0; perr_cfg = 1'b0;

        // Extension table
        foreach (ld_vecs[i]) begin
            rdata_cfg = ld_vecs[i].rd;
            do_req(1'b0, 32'h0000_0300 + i, 32'h0, ld_vecs[i].sz, ld_vecs[i].uns, 20);
            check($sformatf("ld%0d_rdata", i), got_rdata, ld_vecs[i].exp);
            tick();
        end

        // Illegal size: no APB transfer, immediate error response
        do_req(1'b0, 32'h0000_0400, 32'h0, 2'b11, 1'b0, 20);
        check("ill_lat",   lat,               32'd1);
        check("ill_psel",  {31'd0, saw_psel}, 32'd0);
        check("ill_psel_now", {31'd0, psel},  32'd0);
        check("ill_err",   {31'd0, got_err},  32'd1);
        check("ill_rdata", got_rdata,         32'd0);
        tick();

        // Reset in the middle of ACCESS
        wait_cfg = 1000;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h500; req_wdata = 32'h1;
        req_size = 2'b10;
        tick();
        req_valid = 1'b0;
        tick();
        check("rma_in_access", {30'd0, psel, penable}, 32'd3);
        prst = 1'b1;
        tick();
        check("rma_apb_drop", {29'd0, psel, penable, pwrite}, 32'd0);
        check("rma_no_resp",  {31'd0, resp_valid},           32'd0);
        check("rma_ready_rst", {31'd0, req_ready},           32'd0);
        prst = 1'b0;
        #1;
        check("rma_ready",    {31'd0, req_ready},            32'd1);
        begin
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < 4; k++) begin
                tick();
                if (resp_valid || psel) seen = 1'b1;
            end
            check("rma_quiet", {31'd0, seen}, 32'd0);
        end

        // Slave that never answers
        do_req(1'b0, 32'h0000_0600, 32'h0, 2'b10, 1'b0, 40);
`ifdef LSU_TIMEOUT_EN
        check("tmo_resp",  {31'd0, got_resp}, 32'd1);
        check("tmo_lat",   lat,               32'd18);
        check("tmo_err",   {31'd0, got_err},  32'd1);
        check("tmo_rdata", got_rdata,         32'd0);
        tick();
`else
        check("hang_no_resp", {31'd0, got_resp}, 32'd0);
        check("hang_access",  {30'd0, psel, penable}, 32'd3);
        prst = 1'b1;
        tick();
        prst = 1'b0;
        #1;
`endif
        wait_cfg = 0;
        check("end_ready", {31'd0, req_ready}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
